// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron fed by the 9-bit output of an 8-input adder tree.
// The membrane potential leaks by a right shift on every accepted sum, fires when it
// reaches the threshold, then holds off upstream for a refractory window.
module lif_neuron #(
    parameter int VW      = 12,
    parameter int VTH     = 200,
    parameter int LEAK_SH = 3,
    parameter int T_REF   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_sum,
    input  logic          in_co,
    output logic          spike,
    output logic [VW-1:0] v_mem,
    output logic          refrac,
    output logic [15:0]   spike_cnt
);

    typedef enum logic {
        INTEG  = 1'b0,
        REFRAC = 1'b1
    } state_t;

    // Counter load value on a fire; T_REF of zero never enters REFRAC, so its value is irrelevant
    localparam logic [7:0]  REF_INIT = (T_REF > 0) ? 8'(T_REF - 1) : 8'd0;
    localparam logic [VW:0] MAX_V    = {1'b0, {VW{1'b1}}};
    localparam logic [VW-1:0] THRESH = VW'(VTH);

    state_t         r_state;
    logic [7:0]     r_refCnt;
    logic [VW-1:0]  r_vMem;
    logic           r_spike;
    logic [15:0]    r_spikeCnt;

    logic [VW:0]    w_x;
    logic [VW:0]    w_leak;
    logic [VW:0]    w_u;
    logic [VW-1:0]  w_vn;
    logic           w_fire;
    logic           w_accept;

    // Ready depends only on state and reset so upstream never sees a combinational loop through valid
    assign in_ready  = (r_state == INTEG) && !rst;
    assign w_accept  = in_valid && in_ready;

    // Next potential: leak first, then integrate, one bit wider than the register so overflow is visible
    assign w_x    = {{(VW - 8){1'b0}}, in_co, in_sum};
    assign w_leak = {1'b0, r_vMem >> LEAK_SH};
    assign w_u    = {1'b0, r_vMem} - w_leak + w_x;
    assign w_vn   = (w_u > MAX_V) ? {VW{1'b1}} : w_u[VW-1:0];
    assign w_fire = (w_vn >= THRESH);

    assign spike     = r_spike;
    assign v_mem     = r_vMem;
    assign refrac    = (r_state == REFRAC);
    assign spike_cnt = r_spikeCnt;

    // Integrate/fire state machine with registered potential, spike pulse and spike counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INTEG;
            r_refCnt   <= 8'd0;
            r_vMem     <= '0;
            r_spike    <= 1'b0;
            r_spikeCnt <= 16'd0;
        end else begin
            r_spike <= 1'b0;
            case (r_state)
                INTEG: begin
                    if (w_accept) begin
                        if (w_fire) begin
                            r_vMem  <= '0;
                            r_spike <= 1'b1;
                            if (r_spikeCnt != 16'hFFFF) begin
                                r_spikeCnt <= r_spikeCnt + 16'd1;
                            end
                            if (T_REF > 0) begin
                                r_state  <= REFRAC;
                                r_refCnt <= REF_INIT;
                            end
                        end else begin
                            r_vMem <= w_vn;
                        end
                    end
                end
                REFRAC: begin
                    if (r_refCnt == 8'd0) begin
                        r_state <= INTEG;
                    end else begin
                        r_refCnt <= r_refCnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= INTEG;
                end
            endcase
        end
    end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron that consumes the 9-bit synaptic sum (8-bit sum plus carry-out) produced by the 8-input adder tree. It keeps a membrane potential, leaks it by a shift, and compares it to a threshold. On crossing, it emits a one-cycle spike, resets the potential and enforces a refractory window. During that window it back-pressures the upstream adder stage through a valid/ready handshake.

## Interface
Parameters:
- VW, 12, membrane potential width in bits (VW ≥ 10)
- VTH, 200, firing threshold (1 ≤ VTH ≤ 2^VW−1)
- LEAK_SH, 3, leak shift: each update subtracts v >> LEAK_SH (1 ≤ LEAK_SH < VW)
- T_REF, 4, refractory length in cycles (0 ≤ T_REF ≤ 255)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream sum is valid this cycle
- in_ready  out  1  neuron accepts a sum this cycle
- in_sum  in  8  adder-tree sum
- in_co  in  1  adder-tree carry-out; forms bit 8 of the input, x = {in_co, in_sum}, range 0..511
- spike  out  1  registered one-cycle fire pulse
- v_mem  out  VW  registered membrane potential
- refrac  out  1  high while in REFRAC state
- spike_cnt  out  16  registered count of spikes emitted, saturating

## Operation
- One clock (clk). Reset is synchronous and active-high (rst). All state updates occur on the rising edge of clk.
- Reset values:
  - v_mem = 0, spike = 0, spike_cnt = 0, refrac = 0.
  - State = INTEG; refractory counter = 0.
  - in_ready = 0 while rst is high.
- in_ready = (state == INTEG) && !rst. It is combinational from state only and never depends on in_valid.
- Accept event: in_valid && in_ready on a rising edge. Inputs are unsigned.
- Update on accept:
  - Compute u = v_mem − (v_mem >> LEAK_SH) + x at VW+1 bits.
  - Saturate: vn = min(u, 2^VW−1).
- If vn ≥ VTH (fire):
  - v_mem ← 0, spike ← 1.
  - spike_cnt ← spike_cnt+1, holding at 0xFFFF once reached.
  - If T_REF > 0: state ← REFRAC, counter ← T_REF−1. Otherwise stay in INTEG.
- Otherwise: v_mem ← vn, spike ← 0.
- No accept: v_mem holds (no leak without an input; one accepted sum = one timestep), and spike ← 0.
- REFRAC state:
  - in_ready = 0 and refrac = 1. Inputs are ignored and v_mem holds at 0.
  - If counter == 0: state ← INTEG. Otherwise counter ← counter−1.
- States: INTEG → REFRAC on fire when T_REF > 0; REFRAC → INTEG when counter == 0. No other transitions.
- Reset in any state, including mid-refractory, overrides everything: all reset values apply on that edge.

## Timing
- Latency: an accept at edge k updates v_mem at edge k. spike is high for exactly one cycle, from edge k to edge k+1.
- Back-to-back: in INTEG without firing, one sum is accepted every cycle (full throughput).
- After a fire at edge k with T_REF = N > 0:
  - in_ready is low for exactly N cycles (edges k+1..k+N see no accept).
  - in_ready is high again after edge k+N.
- With T_REF = 0, a fire is followed by an accept on the very next cycle if in_valid is high.
- Upstream must hold in_sum/in_co stable while in_valid && !in_ready. The neuron does not latch them.
- Maximum spike rate: one per T_REF+1 cycles.

## Test plan
(defaults: VW=12, VTH=200, LEAK_SH=3, T_REF=4)
- Reset, then three back-to-back accepts of x=100. Required:
  - v_mem = 100, then 188.
  - Third accept fires: v_mem = 0, spike high for 1 cycle, spike_cnt = 1.
- One accept with in_co=1, in_sum=0x2C (x=300). Required: fires immediately, spike next cycle, v_mem = 0.
- Fire, then hold in_valid=1 continuously with x=50. Required:
  - in_ready = 0 and refrac = 1 for exactly 4 cycles; v_mem stays 0.
  - 5th cycle: in_ready = 1 and v_mem becomes 50.
- Accept x=100, then in_valid=0 for 10 cycles. Required: v_mem holds at 100, spike stays 0.
- Assert rst for 1 cycle during the 2nd refractory cycle. Required:
  - Next cycle: in_ready = 1, refrac = 0, v_mem = 0, spike_cnt = 0.
- Override VTH=4095, repeated accepts of x=511. Required:
  - v_mem rises monotonically and settles at exactly 4088.
  - No spike ever; v_mem never exceeds 4095.
